traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
Parametrised single-approach traffic-light controller driving a 3-LED head (red/yellow/green) plus a pedestrian WALK lamp. A built-in prescaler derives a time tick from sys_clk, and every phase length is a parameter counted in ticks. The block adds a latched pedestrian request that shortens green and a night mode that flashes yellow. It replaces the fixed LED sequencer at the top of the road-crossing design.

Parameters:
TICK_DIV, 50, sys_clk cycles per tick (>=1; board build overrides to 27_000_000)
T_RED, 8, red phase length in ticks (>=1)
T_GREEN, 10, nominal green phase length in ticks (>=1)
T_MIN_GREEN, 4, minimum green length in ticks when a pedestrian request is pending (1..T_GREEN)
T_YELLOW, 3, yellow phase length in ticks (>=1)
FLASH_HALF, 2, night-mode half-period in ticks (>=1)
CNT_W, 8, phase counter width; must hold max(T_*)-1

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  synchronous reset, active-low
ped_req  input  1  pedestrian button, synchronous level, sampled every cycle
night_mode  input  1  1 = flashing-yellow mode, sampled every cycle
led  output  3  {red, yellow, green}, one-hot or 000
walk  output  1  pedestrian WALK lamp
phase  output  2  current state: 0 RED, 1 GREEN, 2 YELLOW, 3 FLASH

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-low on sys_rst_n. All state changes happen on the rising edge of sys_clk.
- Reset (sys_rst_n=0 at an edge) sets: state=RED, led=100, walk=1, phase=0. Prescaler, phase counter, ped_pending, blink all go to 0. Reset wins over every other event, including mid-phase.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where the count equals TICK_DIV-1. With TICK_DIV=1, tick is asserted every cycle.
- The prescaler is cleared on reset, on entry to FLASH and on exit from FLASH. Otherwise it runs freely.
- Phase counter: increments on each tick and is cleared on every state transition. A state ends at a tick where phase_cnt == T_state-1. Every phase therefore lasts exactly T_state*TICK_DIV cycles.
- Transitions (evaluated only at ticks, FLASH excepted):
  - RED -> GREEN after T_RED ticks.
  - GREEN -> YELLOW after T_GREEN ticks, or earlier at any tick where ped_pending=1 and phase_cnt >= T_MIN_GREEN-1.
  - YELLOW -> RED after T_YELLOW ticks.
- ped_pending:
  - Set by ped_req=1 in any cycle while the state is GREEN or YELLOW.
  - Cleared on entry to RED, on entry to FLASH, and on reset.
  - ped_req is ignored during RED (walk is already on) and during FLASH.
  - ped_pending has no effect in YELLOW beyond persisting until RED entry.
- night_mode=1:
  - On the next edge, the block enters FLASH from any state, regardless of tick. blink=1.
  - blink toggles after every FLASH_HALF ticks.
  - led={0,blink,0}; walk=0.
- night_mode=0 while in FLASH: on the next edge, state=RED and the phase counter and prescaler are cleared, so the full red phase restarts.
- Outputs are registered and update on the same edge as the state register, with no extra latency.
  - RED: led=100, walk=1.
  - GREEN: led=001, walk=0.
  - YELLOW: led=010, walk=0.
- Simultaneous events, in priority order: reset > night_mode > tick transition > ped_req. A ped_req arriving in the cycle GREEN->YELLOW occurs is latched, then cleared at RED entry.

Test Plan:
All scenarios use TICK_DIV=4, T_RED=3, T_GREEN=5, T_MIN_GREEN=2, T_YELLOW=2, FLASH_HALF=1.
1. Free run: reset 2 cycles then release -> led=100 with walk=1 for 12 cycles, then 001 for 20 cycles, then 010 for 8 cycles, then back to 100. The period is 40 cycles; walk=0 outside RED.
2. Early request: one-cycle ped_req in the first GREEN cycle -> GREEN lasts 8 cycles (2 ticks), YELLOW 8 cycles, then RED 12 cycles. The next GREEN is a full 20 cycles.
3. Late request: ped_req during GREEN tick interval 3 (cycles 12-15 of green) -> GREEN ends after 16 cycles.
4. Ignored request: ped_req held high through an entire RED -> the following GREEN is a full 20 cycles.
5. Night mode: assert night_mode mid-GREEN -> next edge led=010, walk=0, phase=3. led alternates 010/000 every 4 cycles. Deasserting night_mode -> next edge led=100, and red lasts a full 12 cycles.
6. Mid-phase reset: sys_rst_n=0 for 1 cycle in YELLOW with ped_pending set -> led=100, walk=1, phase=0. The following RED lasts 12 cycles and the GREEN after it lasts 20 cycles.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Single-approach traffic-light controller: red/yellow/green head, WALK lamp,
// latched pedestrian request that shortens green, and a flashing-yellow night mode.
// Phase lengths are counted in prescaler ticks derived from sys_clk.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned T_RED       = 8,
  parameter int unsigned T_GREEN     = 10,
  parameter int unsigned T_MIN_GREEN = 4,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned FLASH_HALF  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] led,
  output logic       walk,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } state_e;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] MING_LAST  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  state_e           state_q;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ped_q;
  logic             blink_q;
  logic [2:0]       led_q;
  logic             walk_q;

  logic             tick;
  logic [CNT_W-1:0] cnt_last;
  logic             phase_end;
  logic             green_cut;

  // Tick decode and end-of-phase / early-green-exit conditions
  always_comb begin
    tick = (presc_q == PRESC_LAST);
    cnt_last = RED_LAST;
    unique case (state_q)
      S_RED:    cnt_last = RED_LAST;
      S_GREEN:  cnt_last = GREEN_LAST;
      S_YELLOW: cnt_last = YEL_LAST;
      S_FLASH:  cnt_last = FLASH_LAST;
      default:  cnt_last = RED_LAST;
    endcase
    phase_end = tick && (cnt_q == cnt_last);
    green_cut = tick && ped_q && (cnt_q >= MING_LAST);
  end

  // Controller state, timers, pedestrian latch and registered lamp outputs
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_RED;
      presc_q <= '0;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
      led_q   <= 3'b100;
      walk_q  <= 1'b1;
    end else if (night_mode && (state_q != S_FLASH)) begin
      state_q <= S_FLASH;
      presc_q <= '0;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b1;
      led_q   <= 3'b010;
      walk_q  <= 1'b0;
    end else if (night_mode) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (phase_end) begin
        cnt_q   <= '0;
        blink_q <= ~blink_q;
        led_q   <= {1'b0, ~blink_q, 1'b0};
      end else if (tick) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (state_q == S_FLASH) begin
      // Leaving night mode restarts a complete red phase from a clean prescaler.
      state_q <= S_RED;
      presc_q <= '0;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
      led_q   <= 3'b100;
      walk_q  <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (ped_req && ((state_q == S_GREEN) || (state_q == S_YELLOW))) begin
        ped_q <= 1'b1;
      end
      // Transition assignments come last so they override the counter and latch updates.
      unique case (state_q)
        S_RED: begin
          if (phase_end) begin
            state_q <= S_GREEN;
            cnt_q   <= '0;
            led_q   <= 3'b001;
            walk_q  <= 1'b0;
          end
        end
        S_GREEN: begin
          if (phase_end || green_cut) begin
            state_q <= S_YELLOW;
            cnt_q   <= '0;
            led_q   <= 3'b010;
            walk_q  <= 1'b0;
          end
        end
        S_YELLOW: begin
          if (phase_end) begin
            state_q <= S_RED;
            cnt_q   <= '0;
            ped_q   <= 1'b0;
            led_q   <= 3'b100;
            walk_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RED;
        end
      endcase
    end
  end

  assign led   = led_q;
  assign walk  = walk_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl: expected per-cycle lamp states are queued
// from the phase durations of each scenario and compared cycle by cycle.
module tb_traffic_light_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       ped_req;
  logic       night_mode;
  logic [2:0] led;
  logic       walk;
  logic [1:0] phase;

  typedef struct packed {
    logic [2:0] led;
    logic       walk;
    logic [1:0] phase;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  localparam exp_t R  = '{led: 3'b100, walk: 1'b1, phase: 2'd0};
  localparam exp_t G  = '{led: 3'b001, walk: 1'b0, phase: 2'd1};
  localparam exp_t Y  = '{led: 3'b010, walk: 1'b0, phase: 2'd2};
  localparam exp_t FY = '{led: 3'b010, walk: 1'b0, phase: 2'd3};
  localparam exp_t F0 = '{led: 3'b000, walk: 1'b0, phase: 2'd3};

  traffic_light_ctrl #(
    .TICK_DIV   (4),
    .T_RED      (3),
    .T_GREEN    (5),
    .T_MIN_GREEN(2),
    .T_YELLOW   (2),
    .FLASH_HALF (1),
    .CNT_W      (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ped_req   (ped_req),
    .night_mode(night_mode),
    .led       (led),
    .walk      (walk),
    .phase     (phase)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic push(input exp_t e, input int n);
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Advance one clock, sample just after the edge, and pop the expected entry.
  task automatic advance(output exp_t e);
    @(posedge sys_clk);
    #1;
    e = sb.pop_front();
    vectors++;
  endtask

  task automatic test_reset;
    exp_t e;
    sys_rst_n  = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    @(posedge sys_clk);
    push(R, 1);
    advance(e);
    sys_rst_n = 1'b1;
    if ({led, walk, phase} !== e) begin
      miscompares++;
      $display("FAIL reset: got %b/%b/%0d, want %b/%b/%0d", led, walk, phase, e.led, e.walk, e.phase);
    end
  endtask

  task automatic test_free_run;
    exp_t e;
    push(R, 11); push(G, 20); push(Y, 8); push(R, 12);
    for (int i = 0; i < 51; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL free_run[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
  endtask

  task automatic test_early_req;
    exp_t e;
    push(G, 1);
    advance(e);
    if ({led, walk, phase} !== e) begin
      miscompares++;
      $display("FAIL early_req first green: got %b/%b/%0d, want %b/%b/%0d", led, walk, phase, e.led, e.walk, e.phase);
    end
    ped_req = 1'b1;
    push(G, 7); push(Y, 8); push(R, 12); push(G, 20); push(Y, 8); push(R, 12);
    for (int i = 0; i < 67; i++) begin
      advance(e);
      ped_req = 1'b0;
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL early_req[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
  endtask

  task automatic test_late_req;
    exp_t e;
    push(G, 12);
    for (int i = 0; i < 12; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL late_req pre[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
    ped_req = 1'b1;
    push(G, 4); push(Y, 8); push(R, 12);
    for (int i = 0; i < 24; i++) begin
      advance(e);
      ped_req = 1'b0;
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL late_req[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
  endtask

  task automatic test_ignored_req;
    exp_t e;
    push(G, 20); push(Y, 8);
    for (int i = 0; i < 28; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL ignored_req lead[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
    // Raised in the last yellow cycle and held through red: latched then cleared at red entry.
    ped_req = 1'b1;
    push(R, 12);
    for (int i = 0; i < 12; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL ignored_req red[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
    ped_req = 1'b0;
    push(G, 20); push(Y, 8); push(R, 12);
    for (int i = 0; i < 40; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL ignored_req after[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
  endtask

  task automatic test_night;
    exp_t e;
    push(G, 6);
    for (int i = 0; i < 6; i++) begin
      advance(e);
      ped_req = (i == 2);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL night pre[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
    night_mode = 1'b1;
    push(FY, 4); push(F0, 4); push(FY, 4); push(F0, 4);
    for (int i = 0; i < 16; i++) begin
      advance(e);
      ped_req = (i >= 8);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL night flash[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
    ped_req    = 1'b0;
    night_mode = 1'b0;
    push(R, 12); push(G, 20); push(Y, 8); push(R, 12);
    for (int i = 0; i < 52; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL night exit[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    push(G, 20); push(Y, 1);
    for (int i = 0; i < 21; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL mid_reset lead[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
    ped_req = 1'b1;
    push(Y, 1);
    advance(e);
    ped_req   = 1'b0;
    sys_rst_n = 1'b0;
    if ({led, walk, phase} !== e) begin
      miscompares++;
      $display("FAIL mid_reset yellow: got %b/%b/%0d, want %b/%b/%0d", led, walk, phase, e.led, e.walk, e.phase);
    end
    push(R, 1);
    advance(e);
    sys_rst_n = 1'b1;
    if ({led, walk, phase} !== e) begin
      miscompares++;
      $display("FAIL mid_reset entry: got %b/%b/%0d, want %b/%b/%0d", led, walk, phase, e.led, e.walk, e.phase);
    end
    push(R, 11); push(G, 20); push(Y, 8);
    for (int i = 0; i < 39; i++) begin
      advance(e);
      if ({led, walk, phase} !== e) begin
        miscompares++;
        $display("FAIL mid_reset after[%0d]: got %b/%b/%0d, want %b/%b/%0d", i, led, walk, phase, e.led, e.walk, e.phase);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_free_run();
    test_early_req();
    test_late_req();
    test_ignored_req();
    test_night();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
